// File: rtl/octave_tone_gen_pkg.sv
// Shared types and constants for the octave tone generator.
// Increments assume A4 = 440 Hz at a 10 kHz sample rate.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE
  } tone_state_t;

  localparam int ACC_W_DEF = 18;
  localparam int NUM_NOTES = 12;

  localparam int unsigned NOTE_INC [NUM_NOTES] = '{
    6858, 7266, 7698, 8156,
    8641, 9155, 9699, 10276,
    10887, 11534, 12220, 12947
  };

endpackage

// File: rtl/octave_tone_gen_if.sv
// Control/observe bundle between keypad logic, tone generator and mixer.
// The master drives key/tick inputs; the slave is the generator.
interface octave_tone_gen_if #(
  parameter int ACC_W = synth_pkg::ACC_W_DEF
);
  logic             sample_tick;
  logic             key_on;
  logic [3:0]       key_idx;
  logic [1:0]       oct_switch;
  logic             wave_out;
  logic [ACC_W-1:0] phase;
  logic             busy;
  logic [1:0]       cur_oct;

  modport master (
    output sample_tick,
    output key_on,
    output key_idx,
    output oct_switch,
    input  wave_out,
    input  phase,
    input  busy,
    input  cur_oct
  );

  modport slave (
    input  sample_tick,
    input  key_on,
    input  key_idx,
    input  oct_switch,
    output wave_out,
    output phase,
    output busy,
    output cur_oct
  );
endinterface

// File: rtl/octave_tone_gen_note_inc_lut.sv
// Note index plus octave to phase increment.
// Invalid keys map to zero; callers only latch valid keys.
module note_inc_lut
  import synth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [3:0]       key,
  input  logic [1:0]       oct,
  output logic [ACC_W-1:0] inc
);

  logic [ACC_W-1:0] base;

  always_comb begin
    base = '0;
    if (key < 4'(NUM_NOTES))
      base = ACC_W'(NOTE_INC[key]);
    inc = base >> oct;
  end

endmodule

// File: rtl/octave_tone_gen.sv
// Square-wave tone generator; key and octave changes take
// effect only at a phase wrap so the waveform never glitches.
module octave_tone_gen
  import synth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input logic               clk,
  input logic               nrst,
  octave_tone_gen_if.slave  bus
);

  tone_state_t      state;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] inc;
  logic [3:0]       app_key;
  logic [1:0]       app_oct;
  logic             busy;

  logic             idx_ok;
  logic             key_ok;
  logic [3:0]       lut_key;
  logic [ACC_W-1:0] lut_inc;
  logic [ACC_W:0]   sum;
  logic             wrap;

  assign idx_ok  = bus.key_idx < 4'(NUM_NOTES);
  assign key_ok  = bus.key_on && idx_ok;
  assign lut_key = idx_ok ? bus.key_idx : app_key;
  assign sum     = {1'b0, phase} + {1'b0, inc};
  assign wrap    = sum[ACC_W];

  note_inc_lut #(
    .ACC_W (ACC_W)
  ) u_lut (
    .key (lut_key),
    .oct (bus.oct_switch),
    .inc (lut_inc)
  );

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state   <= IDLE;
      phase   <= '0;
      app_key <= '0;
      app_oct <= '0;
      inc     <= ACC_W'(NOTE_INC[0]);
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          phase <= '0;
          if (key_ok) begin
            app_key <= bus.key_idx;
            app_oct <= bus.oct_switch;
            inc     <= lut_inc;
            state   <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (bus.sample_tick) begin
            phase <= sum[ACC_W-1:0];
            if (wrap) begin
              if (idx_ok)
                app_key <= bus.key_idx;
              app_oct <= bus.oct_switch;
              inc     <= lut_inc;
            end
          end
          if (!key_ok)
            state <= RELEASE;
        end
        RELEASE: begin
          // Draining to the wrap keeps the last period full length
          if (bus.sample_tick && wrap) begin
            phase <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (bus.sample_tick)
              phase <= sum[ACC_W-1:0];
            if (key_ok)
              state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase    = phase;
  assign bus.wave_out = phase[ACC_W-1];
  assign bus.busy     = busy;
  assign bus.cur_oct  = app_oct;

endmodule

// File: tb/tb_octave_tone_gen.sv
// Directed plus random checks of octave_tone_gen against
// an arithmetic note model.
module tb_octave_tone_gen;

  localparam int W    = 18;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int NOTES [12] = '{
    6858, 7266, 7698, 8156, 8641, 9155,
    9699, 10276, 10887, 11534, 12220, 12947
  };

  logic clk = 1'b0;
  logic nrst = 1'b1;

  octave_tone_gen_if #(.ACC_W(W)) bus ();

  octave_tone_gen #(.ACC_W(W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model: sounding / draining flags plus the applied note
  bit m_on, m_rel;
  int m_phase, m_key, m_oct;

  int rec_phase [0:400];
  bit rec_busy  [0:400];
  bit rec_wave  [0:400];
  int rec_oct   [0:400];

  task automatic chk(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_of(int k, int o);
    return NOTES[k] >> o;
  endfunction

  task automatic model_reset();
    m_on = 0; m_rel = 0; m_phase = 0; m_key = 0; m_oct = 0;
  endtask

  task automatic model_clock(bit t, bit on, int k, int o);
    bit valid;
    int s;
    valid = on && (k < 12);
    s = m_phase + step_of(m_key, m_oct);
    if (!m_on) begin
      m_phase = 0;
      if (valid) begin
        m_key = k; m_oct = o; m_on = 1; m_rel = 0;
      end
    end else if (!m_rel) begin
      if (t) begin
        if (s >= MOD) begin
          s -= MOD;
          if (k < 12) m_key = k;
          m_oct = o;
        end
        m_phase = s;
      end
      if (!valid) m_rel = 1;
    end else begin
      if (t && s >= MOD) begin
        m_phase = 0; m_on = 0; m_rel = 0;
      end else begin
        if (t) m_phase = s;
        if (valid) m_rel = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("phase", int'(bus.phase), m_phase);
    chk("busy", int'(bus.busy), int'(m_on));
    chk("cur_oct", int'(bus.cur_oct), m_oct);
    chk("wave_out", int'(bus.wave_out), int'(m_phase >= HALF));
  endtask

  task automatic drive(bit t, bit on, int k, int o);
    bus.sample_tick = t;
    bus.key_on      = on;
    bus.key_idx     = 4'(k);
    bus.oct_switch  = 2'(o);
    @(posedge clk);
    model_clock(t, on, k, o);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bus.sample_tick = 0; bus.key_on = 0;
    bus.key_idx = 0; bus.oct_switch = 0;
    nrst = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    nrst = 1'b0;
  endtask

  // latch cycle carries a tick; ticks alternate with idle cycles
  task automatic tone_run(int k, int o0, int o1, int oct_tick,
                          int rel_tick, int nticks);
    int o;
    bit on;
    drive(1'b1, 1'b1, k, o0);
    chk("latch_no_step", int'(bus.phase), 0);
    for (int t = 1; t <= nticks; t++) begin
      o  = (oct_tick > 0 && t >= oct_tick) ? o1 : o0;
      on = !(rel_tick > 0 && t > rel_tick);
      drive(1'b1, on, k, o);
      rec_phase[t] = int'(bus.phase);
      rec_busy[t]  = bus.busy;
      rec_wave[t]  = bus.wave_out;
      rec_oct[t]   = int'(bus.cur_oct);
      on = !(rel_tick > 0 && t >= rel_tick);
      drive(1'b0, on, k, o);
    end
  endtask

  initial begin
    bus.sample_tick = 0; bus.key_on = 0;
    bus.key_idx = 0; bus.oct_switch = 0;
    model_reset();

    // held A4
    do_reset();
    chk("reset_inc_phase", int'(bus.phase), 0);
    tone_run(9, 0, 0, 0, 0, 24);
    chk("a4_tick1", rec_phase[1], 11534);
    chk("a4_wave_t11", int'(rec_wave[11]), 0);
    chk("a4_wave_t12", int'(rec_wave[12]), 1);
    chk("a4_t12", rec_phase[12], 138408);
    chk("a4_wrap_t23", rec_phase[23], 3138);
    chk("a4_t24", rec_phase[24], 3138 + 11534);

    // octave change mid-period
    do_reset();
    tone_run(9, 0, 1, 5, 0, 24);
    chk("oct_hold_t22", rec_oct[22], 0);
    chk("oct_t22_phase", rec_phase[22], 22 * 11534);
    chk("oct_applied_t23", rec_oct[23], 1);
    chk("oct_t23", rec_phase[23], 3138);
    chk("oct_t24", rec_phase[24], 8905);

    // release drain
    do_reset();
    tone_run(9, 0, 0, 0, 5, 24);
    chk("rel_busy_t6", int'(rec_busy[6]), 1);
    chk("rel_busy_t22", int'(rec_busy[22]), 1);
    chk("rel_phase_t23", rec_phase[23], 0);
    chk("rel_busy_t23", int'(rec_busy[23]), 0);
    chk("rel_idle_t24", rec_phase[24], 0);

    // low octave C
    do_reset();
    tone_run(0, 3, 3, 0, 0, 307);
    chk("low_t2", rec_phase[2], 1714);
    chk("low_t305", rec_phase[305], 305 * 857);
    chk("low_t306", rec_phase[306], 306 * 857 - MOD);
    chk("low_oct", rec_oct[306], 3);

    // invalid key in IDLE, then tick in the latch cycle
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 13, 1);
    chk("inv_busy", int'(bus.busy), 0);
    chk("inv_phase", int'(bus.phase), 0);
    drive(1'b1, 1'b1, 4, 2);
    chk("latch_tick_phase", int'(bus.phase), 0);
    chk("latch_busy", int'(bus.busy), 1);

    // asynchronous reset mid-RUN
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 4, 2);
    chk("pre_reset_nonzero", int'(bus.phase != 0), 1);
    #2;
    nrst = 1'b1;
    model_reset();
    #1;
    chk("areset_phase", int'(bus.phase), 0);
    chk("areset_wave", int'(bus.wave_out), 0);
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_oct", int'(bus.cur_oct), 0);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4, 2);
    chk("post_reset_idle", int'(bus.busy), 0);
    drive(1'b0, 1'b1, 7, 1);
    chk("post_reset_run", int'(bus.busy), 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)),
            1'(($urandom % 16) != 0),
            int'($urandom_range(0, 14)),
            int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
